// File: rtl/pong_pkg.sv
// Shared definitions for the pong ball logic: collision codes, vertical
// direction encodings, controller states and default screen bounds.
package pong_pkg;

    localparam logic [2:0] COLL_NONE = 3'b000;
    localparam logic [2:0] L_TOP     = 3'b001;
    localparam logic [2:0] R_TOP     = 3'b010;
    localparam logic [2:0] R_MID     = 3'b011;
    localparam logic [2:0] R_BOT     = 3'b100;
    localparam logic [2:0] L_BOT     = 3'b101;
    localparam logic [2:0] L_MID     = 3'b110;

    localparam logic [1:0] DIRY_STRAIGHT = 2'b00;
    localparam logic [1:0] DIRY_UP       = 2'b01;
    localparam logic [1:0] DIRY_DOWN     = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_APPLY,
        ST_MOVE
    } state_e;

    localparam logic [7:0] X_MIN_DEF      = 8'd0;
    localparam logic [7:0] X_MAX_DEF      = 8'd159;
    localparam logic [6:0] Y_MIN_DEF      = 7'd0;
    localparam logic [6:0] Y_MAX_DEF      = 7'd117;
    localparam logic [7:0] SERVE_X_DEF    = 8'd80;
    localparam logic [6:0] SERVE_Y_DEF    = 7'd60;
    localparam logic [7:0] LEFT_FACE_DEF  = 8'd42;
    localparam logic [7:0] RIGHT_FACE_DEF = 8'd118;

    // Left-paddle codes push the ball right; right-paddle codes push it left.
    function automatic logic is_left_code(input logic [2:0] code);
        return (code == L_TOP) || (code == L_MID) || (code == L_BOT);
    endfunction

    function automatic logic is_right_code(input logic [2:0] code);
        return (code == R_TOP) || (code == R_MID) || (code == R_BOT);
    endfunction

endpackage

// File: rtl/coll_handshake.sv
// Collision request timing: waits for the checker's done pulse or a timeout,
// then emits a one-cycle valid with the latched code and inner flag.
module coll_handshake
    import pong_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_i,
    input  logic       done_i,
    input  logic [2:0] code_i,
    input  logic       inner_i,
    output logic       valid_o,
    output logic [2:0] code_o,
    output logic       inner_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    code_q, code_d;
    logic          inner_q, inner_d;
    logic          timeout_hit;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign valid_o     = req_i && (done_i || timeout_hit);

    always_comb begin
        cnt_d   = cnt_q;
        code_d  = code_q;
        inner_d = inner_q;
        if (!req_i || valid_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // A timeout is reported as "no collision" so the ball just keeps moving.
        if (valid_o) begin
            code_d  = done_i ? code_i : COLL_NONE;
            inner_d = done_i ? inner_i : 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            code_q  <= COLL_NONE;
            inner_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            inner_q <= inner_d;
        end
    end

    assign code_o  = code_q;
    assign inner_o = inner_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position/direction owner: per frame tick it requests a paddle collision
// result, applies the deflection, then bounces off walls, moves and scores.
module ball_motion_ctrl
    import pong_pkg::*;
#(
    parameter logic [7:0] X_MIN        = X_MIN_DEF,
    parameter logic [7:0] X_MAX        = X_MAX_DEF,
    parameter logic [6:0] Y_MIN        = Y_MIN_DEF,
    parameter logic [6:0] Y_MAX        = Y_MAX_DEF,
    parameter logic [7:0] SERVE_X      = SERVE_X_DEF,
    parameter logic [6:0] SERVE_Y      = SERVE_Y_DEF,
    parameter logic [7:0] LEFT_FACE    = LEFT_FACE_DEF,
    parameter logic [7:0] RIGHT_FACE   = RIGHT_FACE_DEF,
    parameter int         DONE_TIMEOUT = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       gameStart,
    input  logic       tick,
    input  logic [2:0] PCollOut,
    input  logic       PCollInner,
    input  logic       PCollDone,
    output logic       collEnable,
    output logic [7:0] xBall,
    output logic [6:0] yBall,
    output logic       dirX,
    output logic [1:0] dirY,
    output logic       scoreLeft,
    output logic       scoreRight,
    output logic       moveDone,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic       dirx_q, dirx_d;
    logic [1:0] diry_q, diry_d;
    logic [1:0] diry_mv;

    logic       hs_req;
    logic       hs_valid;
    logic [2:0] hs_code;
    logic       hs_inner;

    // Gating with gameStart lets the request drop in the same cycle play stops.
    assign hs_req = (state_q == ST_REQ) && gameStart;

    coll_handshake #(
        .TIMEOUT (DONE_TIMEOUT)
    ) u_coll_handshake (
        .clock   (clock),
        .resetn  (resetn),
        .req_i   (hs_req),
        .done_i  (PCollDone),
        .code_i  (PCollOut),
        .inner_i (PCollInner),
        .valid_o (hs_valid),
        .code_o  (hs_code),
        .inner_o (hs_inner)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dirx_d     = dirx_q;
        diry_d     = diry_q;
        diry_mv    = diry_q;
        scoreLeft  = 1'b0;
        scoreRight = 1'b0;
        moveDone   = 1'b0;

        if (!gameStart) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_WAIT: if (tick) state_d = ST_REQ;
                ST_REQ:  if (hs_valid) state_d = ST_APPLY;
                ST_APPLY: begin
                    state_d = ST_MOVE;
                    // Only honour a paddle that the ball is travelling toward,
                    // so a lingering overlap cannot bounce it twice.
                    if (is_left_code(hs_code) && !dirx_q) begin
                        dirx_d = 1'b1;
                        case (hs_code)
                            L_TOP:   diry_d = DIRY_UP;
                            L_MID:   diry_d = DIRY_STRAIGHT;
                            default: diry_d = DIRY_DOWN;
                        endcase
                        if (hs_inner) x_d = LEFT_FACE;
                    end else if (is_right_code(hs_code) && dirx_q) begin
                        dirx_d = 1'b0;
                        case (hs_code)
                            R_TOP:   diry_d = DIRY_UP;
                            R_MID:   diry_d = DIRY_STRAIGHT;
                            default: diry_d = DIRY_DOWN;
                        endcase
                        if (hs_inner) x_d = RIGHT_FACE;
                    end
                end
                ST_MOVE: begin
                    state_d  = ST_WAIT;
                    moveDone = 1'b1;
                    if (x_q == X_MIN && !dirx_q) begin
                        scoreRight = 1'b1;
                        x_d        = SERVE_X;
                        y_d        = SERVE_Y;
                        dirx_d     = 1'b0;
                        diry_d     = DIRY_STRAIGHT;
                    end else if (x_q == X_MAX && dirx_q) begin
                        scoreLeft = 1'b1;
                        x_d       = SERVE_X;
                        y_d       = SERVE_Y;
                        dirx_d    = 1'b1;
                        diry_d    = DIRY_STRAIGHT;
                    end else begin
                        if (y_q == Y_MIN && diry_q == DIRY_UP) begin
                            diry_mv = DIRY_DOWN;
                        end else if (y_q == Y_MAX && diry_q == DIRY_DOWN) begin
                            diry_mv = DIRY_UP;
                        end
                        diry_d = diry_mv;
                        x_d    = dirx_q ? (x_q + 8'd1) : (x_q - 8'd1);
                        if (diry_mv == DIRY_UP) begin
                            y_d = y_q - 7'd1;
                        end else if (diry_mv == DIRY_DOWN) begin
                            y_d = y_q + 7'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            x_q     <= SERVE_X;
            y_q     <= SERVE_Y;
            dirx_q  <= 1'b1;
            diry_q  <= DIRY_STRAIGHT;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dirx_q  <= dirx_d;
            diry_q  <= diry_d;
        end
    end

    assign collEnable = hs_req;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_WAIT);
    assign xBall      = x_q;
    assign yBall      = y_q;
    assign dirX       = dirx_q;
    assign dirY       = diry_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: each frame's expected outcome is
// predicted by a behavioural model, queued, and compared when moveDone fires.
module tb_ball_motion_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       gameStart = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] PCollOut = 3'b000;
    logic       PCollInner = 1'b0;
    logic       PCollDone = 1'b0;
    logic       collEnable;
    logic [7:0] xBall;
    logic [6:0] yBall;
    logic       dirX;
    logic [1:0] dirY;
    logic       scoreLeft;
    logic       scoreRight;
    logic       moveDone;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         lat;
        int         ce;
        int         sl;
        int         sr;
        logic [7:0] x;
        logic [6:0] y;
        logic       dx;
        logic [1:0] dy;
    } exp_t;

    exp_t sb_q[$];

    logic [7:0] mx;
    logic [6:0] my;
    logic       mdx;
    logic [1:0] mdy;

    ball_motion_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .gameStart  (gameStart),
        .tick       (tick),
        .PCollOut   (PCollOut),
        .PCollInner (PCollInner),
        .PCollDone  (PCollDone),
        .collEnable (collEnable),
        .xBall      (xBall),
        .yBall      (yBall),
        .dirX       (dirX),
        .dirY       (dirY),
        .scoreLeft  (scoreLeft),
        .scoreRight (scoreRight),
        .moveDone   (moveDone),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx  = 8'd80;
        my  = 7'd60;
        mdx = 1'b1;
        mdy = 2'b00;
    endtask

    // Behavioural prediction of one frame; done_at is the REQ cycle carrying PCollDone.
    task automatic predict(input logic [2:0] code, input logic inner, input int done_at);
        exp_t e;
        logic [2:0] c;
        bit got;
        got   = (done_at >= 1) && (done_at <= 4);
        c     = got ? code : 3'b000;
        e.lat = (got ? done_at : 4) + 2;
        e.ce  = got ? done_at : 4;
        e.sl  = 0;
        e.sr  = 0;
        if ((c == 3'b001 || c == 3'b110 || c == 3'b101) && mdx == 1'b0) begin
            mdx = 1'b1;
            mdy = (c == 3'b001) ? 2'b01 : (c == 3'b110) ? 2'b00 : 2'b10;
            if (inner) mx = 8'd42;
        end else if ((c == 3'b010 || c == 3'b011 || c == 3'b100) && mdx == 1'b1) begin
            mdx = 1'b0;
            mdy = (c == 3'b010) ? 2'b01 : (c == 3'b011) ? 2'b00 : 2'b10;
            if (inner) mx = 8'd118;
        end
        if (mx == 8'd0 && mdx == 1'b0) begin
            e.sr = 1;
            mx = 8'd80; my = 7'd60; mdy = 2'b00;
        end else if (mx == 8'd159 && mdx == 1'b1) begin
            e.sl = 1;
            mx = 8'd80; my = 7'd60; mdy = 2'b00;
        end else begin
            if (my == 7'd0 && mdy == 2'b01) mdy = 2'b10;
            else if (my == 7'd117 && mdy == 2'b10) mdy = 2'b01;
            mx = mdx ? mx + 8'd1 : mx - 8'd1;
            if (mdy == 2'b01) my = my - 7'd1;
            else if (mdy == 2'b10) my = my + 7'd1;
        end
        e.x = mx; e.y = my; e.dx = mdx; e.dy = mdy;
        sb_q.push_back(e);
    endtask

    // One tick plus a fixed 10-cycle observation window; extra_tick re-pulses tick in that cycle.
    task automatic frame(input logic [2:0] code, input logic inner, input int done_at, input int extra_tick);
        exp_t e;
        bit have_e;
        int md_cnt, ce_cnt, sl_cnt, sr_cnt;
        predict(code, inner, done_at);
        @(negedge clock);
        tick = 1'b1; PCollOut = code; PCollInner = inner;
        @(posedge clock);
        md_cnt = 0; ce_cnt = 0; sl_cnt = 0; sr_cnt = 0; have_e = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (collEnable) ce_cnt++;
            if (scoreLeft) sl_cnt++;
            if (scoreRight) sr_cnt++;
            if (moveDone) begin
                md_cnt++;
                if (!have_e) begin
                    e = sb_q.pop_front();
                    have_e = 1;
                    check("latency", n, e.lat);
                end
            end
            tick = (n == extra_tick);
            PCollDone = (n == done_at);
        end
        tick = 1'b0; PCollDone = 1'b0;
        if (!have_e) begin
            e = sb_q.pop_front();
            check("latency_timeout", 0, e.lat);
        end
        check("moveDone_count", md_cnt, 1);
        check("collEnable_cycles", ce_cnt, e.ce);
        check("scoreLeft_cycles", sl_cnt, e.sl);
        check("scoreRight_cycles", sr_cnt, e.sr);
        check("xBall", xBall, e.x);
        check("yBall", yBall, e.y);
        check("dirX", dirX, e.dx);
        check("dirY", dirY, e.dy);
        check("busy_idle", busy, 0);
        $display("frame code=%0d inner=%0d done_at=%0d -> x=%0d y=%0d dirX=%0d dirY=%0d", code, inner, done_at, xBall, yBall, dirX, dirY);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, xBall, 80);
        check({tag, "_y"}, yBall, 60);
        check({tag, "_dirX"}, dirX, 1);
        check({tag, "_dirY"}, dirY, 0);
        check({tag, "_collEnable"}, collEnable, 0);
        check({tag, "_scoreLeft"}, scoreLeft, 0);
        check({tag, "_scoreRight"}, scoreRight, 0);
        check({tag, "_moveDone"}, moveDone, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        resetn = 1'b1;
        gameStart = 1'b1;
        @(negedge clock);

        // No done at all: full timeout, straight move right.
        frame(3'b000, 1'b0, 0, 0);
        check("timeout_x81", xBall, 81);
        // Done arriving after REQ has already timed out is ignored.
        frame(3'b010, 1'b0, 6, 0);
        // Right-top hit while moving right: turn left and up.
        frame(3'b010, 1'b0, 1, 0);
        // Right-paddle code while moving left is ignored on every frame.
        for (int k = 0; k < 200 && mx != 8'd41; k++) frame(3'b010, 1'b0, 1, 0);
        check("reach_x41", xBall, 41);
        frame(3'b001, 1'b0, 1, 0);
        check("ltop_x42", xBall, 42);

        for (int k = 0; k < 200 && !(my == 7'd0 && mdy == 2'b01); k++) frame(3'b000, 1'b0, 1, 0);
        check("reach_top", yBall, 0);
        frame(3'b000, 1'b0, 1, 0);
        check("top_bounce_y", yBall, 1);
        check("top_bounce_dir", dirY, 2);

        for (int k = 0; k < 200 && mx != 8'd118; k++) frame(3'b000, 1'b0, 2, 0);
        check("reach_x118", xBall, 118);
        frame(3'b100, 1'b1, 2, 0);
        check("rbot_inner_x", xBall, 117);
        check("rbot_inner_dirY", dirY, 2);

        for (int k = 0; k < 200 && !(my == 7'd117 && mdy == 2'b10); k++) frame(3'b000, 1'b0, 3, 0);
        check("reach_bottom", yBall, 117);
        frame(3'b000, 1'b0, 4, 0);
        check("bottom_bounce_y", yBall, 116);
        check("bottom_bounce_dir", dirY, 1);

        for (int k = 0; k < 200 && mx != 8'd0; k++) frame(3'b000, 1'b0, 1, 0);
        check("reach_x0", xBall, 0);
        frame(3'b000, 1'b0, 1, 0);
        check("scoreR_serve_dirX", dirX, 0);

        frame(3'b110, 1'b0, 1, 0);
        for (int k = 0; k < 200 && mx != 8'd159; k++) frame(3'b000, 1'b0, 1, 0);
        check("reach_x159", xBall, 159);
        frame(3'b000, 1'b0, 1, 0);
        check("scoreL_serve_x", xBall, 80);
        check("scoreL_serve_dirX", dirX, 1);

        // Second tick during REQ must be dropped.
        frame(3'b011, 1'b0, 3, 2);
        frame(3'b010, 1'b1, 1, 0);
        check("ignored_rtop_x", xBall, 78);

        // gameStart dropped in REQ.
        @(negedge clock);
        tick = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tick = 1'b0;
        check("drop_collEnable_req", collEnable, 1);
        gameStart = 1'b0;
        #1;
        check("drop_collEnable_now", collEnable, 0);
        @(negedge clock);
        check("drop_busy", busy, 0);
        check("drop_collEnable_next", collEnable, 0);
        repeat (4) begin
            @(negedge clock);
            check("drop_no_moveDone", moveDone, 0);
        end
        check("drop_x_held", xBall, mx);
        check("drop_y_held", yBall, my);
        $display("gameStart drop -> x=%0d y=%0d busy=%0d", xBall, yBall, busy);
        gameStart = 1'b1;
        @(negedge clock);

        // Asynchronous reset while in APPLY.
        @(negedge clock);
        tick = 1'b1;
        PCollOut = 3'b101;
        @(posedge clock);
        @(negedge clock);
        tick = 1'b0;
        PCollDone = 1'b1;
        @(negedge clock);
        PCollDone = 1'b0;
        check("apply_busy", busy, 1);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        $display("reset in APPLY -> x=%0d y=%0d busy=%0d", xBall, yBall, busy);
        @(negedge clock);
        resetn = 1'b1;
        frame(3'b000, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Consumes the paddle-collision result (3-bit code, inner flag, done pulse) and owns the ball's position and direction registers.
- Once per frame tick: requests a collision evaluation, waits for the done handshake, applies the deflection, then handles wall bounce, movement and scoring.
- Sits between the frame-tick generator and the draw/score logic; its x/y outputs feed the collision checker and the renderer.

Parameters:
- X_MIN, 0, leftmost ball x; reaching it while moving left scores for right player
- X_MAX, 159, rightmost ball x; reaching it while moving right scores for left player
- Y_MIN, 0, top wall ball y
- Y_MAX, 117, bottom wall ball y
- SERVE_X, 80, serve x position
- SERVE_Y, 60, serve y position
- LEFT_FACE, 42, x snapped to on a left inner hit
- RIGHT_FACE, 118, x snapped to on a right inner hit
- DONE_TIMEOUT, 4, cycles to wait for PCollDone before treating result as no collision

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- gameStart  in  1  level; high = play enabled
- tick  in  1  one-cycle frame-step strobe
- PCollOut  in  3  collision code
- PCollInner  in  1  inner-face hit flag, valid with PCollDone
- PCollDone  in  1  collision result valid pulse
- collEnable  out  1  collision evaluation request
- xBall  out  8  ball x
- yBall  out  7  ball y
- dirX  out  1  0 = moving left, 1 = moving right
- dirY  out  2  00 straight, 01 up (y-1), 10 down (y+1); 11 never driven
- scoreLeft  out  1  one-cycle pulse, left player scored
- scoreRight  out  1  one-cycle pulse, right player scored
- moveDone  out  1  one-cycle pulse, position updated this cycle
- busy  out  1  high in any state other than IDLE/WAIT

Behaviour:
- Clock is clock; reset is resetn, asynchronous, active-low.
- Reset values: xBall=SERVE_X, yBall=SERVE_Y, dirX=1, dirY=00. collEnable, scoreLeft, scoreRight, moveDone and busy are 0. FSM is in IDLE.
- States: IDLE, WAIT, REQ, APPLY, MOVE.
- IDLE:
  - gameStart high -> WAIT.
- WAIT:
  - tick -> REQ.
  - collEnable is asserted in REQ: cycle T+1 after a tick at T.
- REQ:
  - Holds collEnable=1.
  - On a cycle with PCollDone=1: latch PCollOut/PCollInner, go to APPLY.
  - Otherwise count; after DONE_TIMEOUT cycles latch code 000, go to APPLY.
- APPLY (collEnable=0):
  - 001 -> dirX=1, dirY=01.
  - 110 -> dirX=1, dirY=00.
  - 101 -> dirX=1, dirY=10.
  - 010 -> dirX=0, dirY=01.
  - 011 -> dirX=0, dirY=00.
  - 100 -> dirX=0, dirY=10.
  - Left codes (001/110/101) are honoured only when dirX=0; right codes (010/011/100) only when dirX=1. Otherwise they are ignored, which prevents a double bounce.
  - 000 and 111 are ignored.
  - Honoured code with inner=1: xBall snaps to LEFT_FACE (left codes) or RIGHT_FACE (right codes) in this cycle.
- MOVE:
  - Wall check first: y==Y_MIN with dirY=01 -> dirY=10; y==Y_MAX with dirY=10 -> dirY=01. The reflected direction is used for this step.
  - Then x+=/-1 and y+=/-1 per direction.
  - Score check uses pre-move x. x==X_MIN with dirX=0 -> scoreRight pulse, reload SERVE_X/SERVE_Y, dirX=0 (serve toward conceder), dirY=00, no move.
  - x==X_MAX with dirX=1 -> scoreLeft pulse, reload, dirX=1, dirY=00.
  - moveDone pulses this cycle; then -> WAIT.
  - Total latency tick -> moveDone: 3 cycles minimum (done in first REQ cycle); DONE_TIMEOUT+2 maximum.
- tick arriving outside WAIT is dropped, not queued.
- gameStart low in any state -> IDLE next cycle. Position/direction held; collEnable drops immediately.
- PCollDone while not in REQ is ignored.
- Arithmetic: x is 8-bit, y is 7-bit, unsigned. Boundary checks precede increment, so no wrap occurs.
- Reset mid-operation returns all registers to reset values asynchronously.

Decomposition:
- Shared package pong_pkg holds:
  - the collision-code constants (COLL_NONE=000, L_TOP=001, R_TOP=010, R_MID=011, R_BOT=100, L_BOT=101, L_MID=110);
  - the dirY encodings;
  - the FSM state typedef;
  - the screen-bound defaults.
- One natural sub-module: coll_handshake. It contains REQ timing, timeout counter and result latch, and outputs a valid pulse plus the latched code/inner flag.

Test Plan:
- Reset, gameStart=1, tick, PCollDone never asserted -> collEnable for 4 cycles, moveDone at tick+6, x=81, y=60, dirX=1.
- dirX=0, x=41, PCollOut=001 with PCollDone in first REQ cycle -> dirX=1, dirY=01, x=42, y decremented; moveDone at tick+3.
- dirX=1, x=118, PCollOut=100 with PCollInner=1 -> x snapped to 118 then moved to 117, dirX=0, dirY=10.
- y=0, dirY=01, no collision -> dirY=10, y=1; y=117, dirY=10 -> dirY=01, y=116.
- x=0, dirX=0, tick -> scoreRight pulses 1 cycle, x=80, y=60, dirX=0, dirY=00. Mirror at x=159 -> scoreLeft, dirX=1.
- Cases combined:
  - tick asserted during REQ -> ignored, single moveDone;
  - PCollOut=010 while dirX=0 -> direction unchanged;
  - gameStart dropped in REQ -> IDLE, collEnable=0 next cycle;
  - resetn pulsed low mid-APPLY -> all outputs at reset values immediately.
